// File: rtl/evt_global_packer.sv
// evt_global_packer: frames engine/memory event streams into
// header + payload (+ EOP tail) packets on one outbound stream.
module evt_global_packer #(
    parameter int MAX_PKT_WORDS  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        bus_clk_i,
    input  logic        bus_rst_i,
    input  logic        flush_i,
    input  logic        evt_stream_engine_dst_valid,
    output logic        evt_stream_engine_dst_ready,
    input  logic [31:0] evt_stream_engine_dst_evt,
    input  logic        evt_stream_memory_dst_valid,
    output logic        evt_stream_memory_dst_ready,
    input  logic [31:0] evt_stream_memory_dst_evt,
    output logic        evt_stream_src_valid,
    input  logic        evt_stream_src_ready,
    output logic [31:0] evt_stream_src_evt,
    output logic        busy_o,
    output logic [15:0] pkt_sent_o
);
    localparam int CW    = $clog2(MAX_PKT_WORDS + 1);
    localparam int AW    = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Event word: [31:28] spike.operation, [27:24] header.gdst, [15:0] header.length
    localparam logic [3:0] OP_EOP     = 4'h7;
    localparam logic [3:0] DST_ENGINE = 4'h1;
    localparam logic [3:0] DST_MEMORY = 4'h2;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] HEADER  = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] TAIL    = 3'd4;

    localparam logic SRC_ENGINE = 1'b0;
    localparam logic SRC_MEMORY = 1'b1;

    logic [2:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   pkt_sent_q, pkt_sent_d;
    logic [31:0]   buf_q [DEPTH];

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_evt;
    logic          accept;
    logic          close;
    logic          done;
    logic [CW-1:0] count_acc;
    logic [CW-1:0] len_m1;
    logic [TW-1:0] timer_inc;
    logic [31:0]   hdr_word;

    assign in_valid  = sel_q ? evt_stream_memory_dst_valid : evt_stream_engine_dst_valid;
    assign in_evt    = sel_q ? evt_stream_memory_dst_evt : evt_stream_engine_dst_evt;
    assign in_ready  = (state_q == COLLECT) && (count_q < MAX_CNT);
    assign accept    = in_ready && in_valid;
    assign count_acc = count_q + CW'(accept);
    assign len_m1    = count_q - CW'(1);
    assign timer_inc = timer_q + TW'(1);

    assign evt_stream_engine_dst_ready = in_ready && (sel_q == SRC_ENGINE);
    assign evt_stream_memory_dst_ready = in_ready && (sel_q == SRC_MEMORY);

    // Full, timeout and flush can coincide; they merge into one close.
    assign close = (count_acc == MAX_CNT)
                || (!accept && timer_inc == TMO_LAST && count_q != '0)
                || (flush_i && count_acc != '0);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        timer_d    = timer_q;
        pkt_sent_d = pkt_sent_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (evt_stream_engine_dst_valid || evt_stream_memory_dst_valid) begin
                    if (evt_stream_engine_dst_valid && evt_stream_memory_dst_valid)
                        sel_d = rr_q;
                    else
                        sel_d = evt_stream_memory_dst_valid;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                count_d = count_acc;
                timer_d = accept ? '0 : timer_inc;
                if (close)
                    state_d = HEADER;
            end
            HEADER: begin
                if (evt_stream_src_ready) begin
                    state_d  = PAYLOAD;
                    rd_ptr_d = '0;
                end
            end
            PAYLOAD: begin
                if (evt_stream_src_ready) begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    if (rd_ptr_q == len_m1) begin
                        if (sel_q == SRC_MEMORY)
                            done = 1'b1;
                        else
                            state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (evt_stream_src_ready)
                    done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d    = IDLE;
            pkt_sent_d = pkt_sent_q + 16'd1;
            rr_d       = ~sel_q;
            count_d    = '0;
            rd_ptr_d   = '0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge bus_clk_i) begin
        if (bus_rst_i) begin
            state_q    <= IDLE;
            sel_q      <= SRC_ENGINE;
            rr_q       <= SRC_ENGINE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            timer_q    <= '0;
            pkt_sent_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            timer_q    <= timer_d;
            pkt_sent_q <= pkt_sent_d;
        end
    end

    always_ff @(posedge bus_clk_i) begin
        if (accept)
            buf_q[count_q[AW-1:0]] <= in_evt;
    end

    always_comb begin
        hdr_word        = '0;
        hdr_word[27:24] = sel_q ? DST_MEMORY : DST_ENGINE;
        hdr_word[15:0]  = sel_q ? 16'(len_m1) : 16'hFFFF;
    end

    always_comb begin
        evt_stream_src_valid = 1'b0;
        evt_stream_src_evt   = '0;
        case (state_q)
            HEADER: begin
                evt_stream_src_valid = 1'b1;
                evt_stream_src_evt   = hdr_word;
            end
            PAYLOAD: begin
                evt_stream_src_valid = 1'b1;
                evt_stream_src_evt   = buf_q[rd_ptr_q[AW-1:0]];
            end
            TAIL: begin
                evt_stream_src_valid = 1'b1;
                evt_stream_src_evt   = {OP_EOP, 28'h0};
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign pkt_sent_o = pkt_sent_q;

endmodule

// File: tb/tb_evt_global_packer.sv
// tb_evt_global_packer: directed + randomized checks of packet framing
// against a packet-level reference model of the packer.
module tb_evt_global_packer;
    localparam int MAXW = 16;
    localparam int TMO  = 64;
    localparam logic [3:0] DST_ENG = 4'h1;
    localparam logic [3:0] DST_MEM = 4'h2;
    localparam logic [31:0] EOP_W = 32'h7000_0000;

    logic        clk = 1'b0;
    logic        bus_rst_i;
    logic        flush_i;
    logic        e_valid, e_ready;
    logic [31:0] e_evt;
    logic        m_valid, m_ready;
    logic [31:0] m_evt;
    logic        o_valid, o_ready;
    logic [31:0] o_evt;
    logic        busy_o;
    logic [15:0] pkt_sent_o;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_pct = 0;
    int cyc = 0;
    int last_e = 0, last_m = 0, vrise = 0;
    logic rise_erdy = 1'b0;
    bit e_acc = 0, m_acc = 0;
    bit rr_m = 0;
    int pkts_m = 0;

    logic [31:0] eq[$];
    logic [31:0] mq[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    evt_global_packer #(.MAX_PKT_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
        .bus_clk_i                   (clk),
        .bus_rst_i                   (bus_rst_i),
        .flush_i                     (flush_i),
        .evt_stream_engine_dst_valid (e_valid),
        .evt_stream_engine_dst_ready (e_ready),
        .evt_stream_engine_dst_evt   (e_evt),
        .evt_stream_memory_dst_valid (m_valid),
        .evt_stream_memory_dst_ready (m_ready),
        .evt_stream_memory_dst_evt   (m_evt),
        .evt_stream_src_valid        (o_valid),
        .evt_stream_src_ready        (o_ready),
        .evt_stream_src_evt          (o_evt),
        .busy_o                      (busy_o),
        .pkt_sent_o                  (pkt_sent_o)
    );

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mk_hdr(logic [3:0] dst, logic [15:0] len);
        logic [31:0] w;
        w = '0;
        w[27:24] = dst;
        w[15:0] = len;
        return w;
    endfunction

    // Packet-level model: whole queues present up front, arbitration per packet.
    function automatic void build(logic [31:0] ew[$], logic [31:0] mw[$]);
        int n;
        bit s;
        while (ew.size() + mw.size() > 0) begin
            if (ew.size() == 0) s = 1;
            else if (mw.size() == 0) s = 0;
            else s = rr_m;
            if (!s) begin
                n = (ew.size() > MAXW) ? MAXW : ew.size();
                exp_q.push_back(mk_hdr(DST_ENG, 16'hFFFF));
                repeat (n) exp_q.push_back(ew.pop_front());
                exp_q.push_back(EOP_W);
            end else begin
                n = (mw.size() > MAXW) ? MAXW : mw.size();
                exp_q.push_back(mk_hdr(DST_MEM, 16'(n - 1)));
                repeat (n) exp_q.push_back(mw.pop_front());
            end
            rr_m = !s;
            pkts_m++;
        end
    endfunction

    task automatic wait_done(string tag, int budget);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            ok = (eq.size() == 0) && (mq.size() == 0) && !busy_o
                 && (got.size() >= exp_q.size());
        end
        check({tag, "_done"}, 64'(ok), 64'(1));
    endtask

    task automatic compare(string tag);
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        check({tag, "_pkts"}, 64'(pkt_sent_o), 64'(16'(pkts_m)));
        got.delete();
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Producers and output-ready driver.
    initial begin
        e_valid = 0; e_evt = '0;
        m_valid = 0; m_evt = '0;
        o_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (e_acc && eq.size() > 0) void'(eq.pop_front());
            if (m_acc && mq.size() > 0) void'(mq.pop_front());
            e_valid = (eq.size() > 0);
            e_evt   = e_valid ? eq[0] : '0;
            m_valid = (mq.size() > 0);
            m_evt   = m_valid ? mq[0] : '0;
            o_ready = ($urandom_range(99, 0) >= stall_pct);
        end
    end

    // Output monitor with hold-while-stalled check.
    initial begin
        bit hold;
        bit prev_v;
        logic [31:0] prev_evt;
        hold = 0; prev_v = 0; prev_evt = '0;
        forever begin
            @(negedge clk);
            e_acc = e_valid && e_ready;
            m_acc = m_valid && m_ready;
            if (e_acc) last_e = cyc;
            if (m_acc) last_m = cyc;
            if (o_valid && !prev_v) begin
                vrise = cyc;
                rise_erdy = e_ready;
            end
            prev_v = o_valid;
            if (hold)
                check("stall_hold", {31'b0, o_valid, o_evt}, {32'd1, prev_evt});
            hold = o_valid && !o_ready && !bus_rst_i;
            prev_evt = o_evt;
            if (o_valid && o_ready) got.push_back(o_evt);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ew[$];
        logic [31:0] mw[$];
        logic [31:0] w1;
        int pk;
        bit ok;

        bus_rst_i = 1; flush_i = 0;
        repeat (3) tick();
        check("rst_valid", 64'(o_valid), 64'(0));
        check("rst_evt", 64'(o_evt), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_pkts", 64'(pkt_sent_o), 64'(0));
        check("rst_rdy", {62'b0, e_ready, m_ready}, 64'(0));
        bus_rst_i = 0;
        tick();

        // memory packet closed by timeout
        ew = {};
        mw = {32'hA1, 32'hA2, 32'hA3};
        build(ew, mw);
        foreach (mw[i]) mq.push_back(mw[i]);
        wait_done("mem_tmo", 1000);
        check("mem_tmo_lat", 64'(vrise - last_m), 64'(TMO));
        compare("mem_tmo");

        // engine packet closed by full buffer
        ew = {}; mw = {};
        for (int i = 0; i < 16; i++) ew.push_back(32'h100 + 32'(i));
        build(ew, mw);
        foreach (ew[i]) eq.push_back(ew[i]);
        wait_done("eng_full", 1000);
        check("eng_full_lat", 64'(vrise - last_e), 64'(1));
        check("eng_full_rdy", 64'(rise_erdy), 64'(0));
        compare("eng_full");

        // both sources valid from reset: round-robin
        bus_rst_i = 1;
        tick();
        got.delete(); exp_q.delete();
        rr_m = 0; pkts_m = 0;
        ew = {}; mw = {};
        for (int i = 0; i < 20; i++) ew.push_back(32'h200 + 32'(i));
        for (int i = 0; i < 3; i++) mw.push_back(32'h300 + 32'(i));
        build(ew, mw);
        foreach (ew[i]) eq.push_back(ew[i]);
        foreach (mw[i]) mq.push_back(mw[i]);
        tick();
        check("rr_rst_pkts", 64'(pkt_sent_o), 64'(0));
        bus_rst_i = 0;
        wait_done("rr", 3000);
        compare("rr");

        // single memory word then flush
        ew = {}; mw = {32'h0000_00B7};
        build(ew, mw);
        mq.push_back(mw[0]);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            ok = (mq.size() == 0);
        end
        check("flush_acc", 64'(ok), 64'(1));
        flush_i = 1;
        tick();
        flush_i = 0;
        wait_done("flush", 200);
        compare("flush");

        // flush in IDLE with nothing buffered
        pk = pkts_m;
        flush_i = 1;
        tick();
        flush_i = 0;
        repeat (5) tick();
        check("idle_flush_busy", 64'(busy_o), 64'(0));
        check("idle_flush_valid", 64'(o_valid), 64'(0));
        check("idle_flush_out", 64'(got.size()), 64'(0));
        check("idle_flush_pkts", 64'(pkt_sent_o), 64'(16'(pk)));

        // flush coinciding with the 16th accept
        ew = {}; mw = {};
        for (int i = 0; i < 16; i++) ew.push_back(32'h400 + 32'(i));
        build(ew, mw);
        foreach (ew[i]) eq.push_back(ew[i]);
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            tick();
            ok = (eq.size() == 1);
        end
        check("ff_reach", 64'(ok), 64'(1));
        flush_i = 1;
        tick();
        flush_i = 0;
        wait_done("flush_full", 500);
        compare("flush_full");

        // randomized traffic with 30% output stalls
        stall_pct = 30;
        for (int r = 0; r < 4; r++) begin
            int ne, nm;
            ne = $urandom_range(40, 0);
            nm = $urandom_range(40, 0);
            if (ne + nm == 0) ne = 1;
            ew = {}; mw = {};
            for (int i = 0; i < ne; i++) ew.push_back($urandom);
            for (int i = 0; i < nm; i++) mw.push_back($urandom);
            build(ew, mw);
            foreach (ew[i]) eq.push_back(ew[i]);
            foreach (mw[i]) mq.push_back(mw[i]);
            wait_done($sformatf("rnd%0d", r), 5000);
            compare($sformatf("rnd%0d", r));
        end
        stall_pct = 0;
        tick();

        // reset while the second payload word is on the output
        ew = {};
        for (int i = 0; i < 5; i++) ew.push_back($urandom);
        w1 = ew[1];
        foreach (ew[i]) eq.push_back(ew[i]);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            tick();
            ok = o_valid && (o_evt == w1) && (got.size() == 2);
        end
        check("mid_rst_reach", 64'(ok), 64'(1));
        bus_rst_i = 1;
        eq.delete(); mq.delete();
        tick();
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        check("mid_rst_pkts", 64'(pkt_sent_o), 64'(0));
        bus_rst_i = 0;
        got.delete(); exp_q.delete();
        rr_m = 0; pkts_m = 0;
        ew = {}; mw = {32'hC1, 32'hC2};
        build(ew, mw);
        foreach (mw[i]) mq.push_back(mw[i]);
        wait_done("post_rst", 500);
        compare("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/evt_global_packer.md
# evt_global_packer

Transmit-side counterpart of the global event router: collects events from the engine and memory return streams, frames them into packets (header word, payload words, optional EOP tail) and emits them on a single event stream toward the bus. Sits in the bus clock domain between the engine/memory producers and the outbound interconnect; its packets are exactly what the global router on the far side parses.

## Interface
- T, default sne_evt_stream_pkg 32-bit event type; event word type with `header.gdst`, `header.length`, `spike.operation` views.
- MAX_PKT_WORDS, default 16; payload words per packet before forced close; legal 1..65535.
- TIMEOUT_CYCLES, default 64; idle cycles in collection before a partial packet is closed; legal ≥ 2.
- bus_clk_i  in  1  clock; single clock domain.
- bus_rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  close the packet under collection at the next cycle boundary (ignored when nothing is buffered).
- evt_stream_engine_dst  SNE_EVENT_STREAM.dst  valid/ready/evt[31:0]  engine-originated events.
- evt_stream_memory_dst  SNE_EVENT_STREAM.dst  valid/ready/evt[31:0]  memory-originated events.
- evt_stream_src  SNE_EVENT_STREAM.src  valid/ready/evt[31:0]  framed packet output.
- busy_o  out  1  high in any state but IDLE.
- pkt_sent_o  out  16  count of fully emitted packets; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, COLLECT, HEADER, PAYLOAD, TAIL.
- IDLE: both input readys low. If any input valid, select source: single valid source wins; both valid → source indicated by round-robin pointer `rr_q` (reset = engine). Go COLLECT with `sel_q` latched.
- COLLECT: selected input ready = (count < MAX_PKT_WORDS); other input ready = 0. Each accepted word written to internal buffer (depth MAX_PKT_WORDS), count+1, idle timer cleared. Idle timer increments on cycles with no accept.
- COLLECT exit to HEADER when any of: count reaches MAX_PKT_WORDS (including via this cycle's accept); idle timer reaches TIMEOUT_CYCLES−1 with count > 0; flush_i with count > 0 (accept in same cycle is included in packet).
- HEADER: drive header word: all-zero word with `header.gdst` = DST_ENGINE or DST_MEMORY per sel_q; `header.length` = count−1 for memory, 16'hFFFF for engine (engine packets terminated by EOP only). Hold until ready → PAYLOAD.
- PAYLOAD: drain buffer in arrival order, one word per handshake. After last word: memory → IDLE; engine → TAIL.
- TAIL: drive all-zero word with `spike.operation` = EOP; on handshake → IDLE.
- On leaving to IDLE: pkt_sent_o +1, rr_q points to the source not just served, count and buffer pointers cleared.
- Engine payload words whose `spike.operation` equals EOP are passed unchanged (producer contract forbids them; no filtering).

## Timing
- Reset (synchronous, bus_rst_i high at a clock edge): state IDLE, all input readys 0, evt_stream_src.valid 0, evt_stream_src.evt 0, busy_o 0, pkt_sent_o 0, rr_q = engine, count/timer/pointers 0. Reset mid-packet discards buffered data; no partial packet completes.
- Input readys are functions of state and count only, never of input valid.
- Output valid, once high, stays high with evt stable until ready; valid never depends on ready.
- First word accepted in the first COLLECT cycle (input valid held per protocol).
- Full trigger: MAX-th word accepted at cycle t → header valid at t+1.
- Timeout: last accept at t → header valid at t+TIMEOUT_CYCLES.
- With output ready held high: header, N payload words and tail occupy consecutive cycles; one IDLE cycle between packets.
- flush_i and full in same cycle: single close, no duplicate header.

## Test plan
- Memory sends 0xA1,0xA2,0xA3 then goes idle, dst ready=1 → after 64 cycles header gdst=DST_MEMORY length=2, then A1,A2,A3; pkt_sent_o=1; no EOP.
- Engine streams 16 words continuously → header gdst=DST_ENGINE length=0xFFFF at cycle after 16th accept, 16 words in order, EOP word; engine ready low while 16 buffered.
- Engine and memory both valid from reset → engine packet first, then memory, then engine again (round-robin), pkt_sent_o increments 1,2,3.
- Output ready toggled randomly 30% → output evt stable while valid&!ready, sequence identical to unstalled run.
- One memory word then flush_i pulse → header length=0, single payload word, back to IDLE; flush_i in IDLE with no valid → no output.
- bus_rst_i asserted during PAYLOAD word 2 → next cycle valid=0, busy_o=0, pkt_sent_o=0; next packet framed correctly from a fresh header.
